stack_push_seq: RTL
===================

Name: stack_push_seq

Overview:
Write-side counterpart to the CPU's byte-assembling address/data latch. It takes a 16-bit word (PC or vector-return address), plus an optional status byte, and serialises it onto the 8-bit data bus as stack writes. Order is high byte, then low byte, then status. The stack pointer is decremented after every byte. JSR, BRK, IRQ and NMI sequences use it. It sits between the control unit and the external address/data bus mux.

Parameters:
STACK_PAGE, 8'h01, high byte of every generated stack address.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a push sequence; sampled only in IDLE
word_in  input  16  word to push; captured on accepted start
status_in  input  8  status byte; captured on accepted start
push_status  input  1  when 1, a third byte (status) is pushed; captured on accepted start
sp_in  input  8  stack pointer at start; captured on accepted start
bus_rdy  input  1  when 0, current write is held and the FSM does not advance
addr_out  output  16  bus address, {STACK_PAGE, sp} during writes, 16'h0000 otherwise
data_out  output  8  byte being written; 8'h00 when not writing
we  output  1  write strobe, high for every cycle spent in a PUSH state
busy  output  1  high from the cycle after an accepted start through the DONE cycle
done  output  1  one-cycle pulse in DONE state
sp_out  output  8  working stack pointer, valid to the control unit when done=1

Behaviour:
- Reset, asynchronous, asserted any time including mid-sequence:
  - state=IDLE.
  - sp=8'hFF, word/status registers 0, push_status latch 0.
  - we=0, busy=0, done=0, addr_out=16'h0000, data_out=8'h00, sp_out=8'hFF.
  - An interrupted sequence is abandoned; no further writes occur.
- States: IDLE, PUSH_H, PUSH_L, PUSH_P, DONE. State register is registered; outputs decode from state plus registers (Moore).
- IDLE:
  - start=1 captures word_in, status_in, push_status and sp_in, then moves to PUSH_H.
  - start=0 stays in IDLE.
- PUSH_H: we=1, addr_out={STACK_PAGE,sp}, data_out=word[15:8].
  - bus_rdy=1: sp<=sp-1 and go to PUSH_L.
  - bus_rdy=0: stay; outputs stable.
- PUSH_L: same rules with data_out=word[7:0]. On bus_rdy=1: sp<=sp-1, then go to PUSH_P if the push_status latch is 1, else DONE.
- PUSH_P: same rules with data_out=status. On bus_rdy=1: sp<=sp-1, then go to DONE.
- DONE: done=1, busy=1, we=0. Next cycle go to IDLE unconditionally. bus_rdy is ignored.
- Latency with bus_rdy held 1, counted from the start cycle:
  - First write at cycle +1.
  - 2-byte sequence: done at cycle +3.
  - 3-byte sequence: done at cycle +4.
  - Each cycle of bus_rdy=0 during a PUSH state adds one cycle.
- SP arithmetic: 8-bit modulo, 8'h00 - 1 = 8'hFF. Wraps within STACK_PAGE; addr_out never leaves the stack page.
- sp_out continuously reflects the working sp register. It equals sp_in minus the number of bytes pushed (mod 256) when done=1.
- start while not in IDLE, including the DONE cycle, is ignored and is not queued.
- Changes on word_in, status_in, push_status or sp_in after capture have no effect on the running sequence.
- start and bus_rdy=0 in the same cycle in IDLE: start is still accepted; bus_rdy only stalls PUSH states.

Test Plan:
1. Reset, then idle checks → addr_out=0000, data_out=00, we=0, busy=0, done=0, sp_out=FF.
2. start, word_in=C0DE, sp_in=FD, push_status=0, bus_rdy=1 → cycle+1 we=1, addr 01FD/data C0. Cycle+2 addr 01FC/data DE. Cycle+3 done=1, sp_out=FB, we=0. Cycle+4 busy=0.
3. start, word_in=1234, status_in=A5, sp_in=01, push_status=1 → writes 0101/12, 0100/34, 01FF/A5 (wrap). done with sp_out=FE.
4. Same as 2, with bus_rdy=0 for 2 cycles during PUSH_L → 01FC/DE held for 3 cycles with we=1. done at cycle+5, sp_out=FB, exactly 2 bytes written.
5. Assert start again during PUSH_H and DONE, and change word_in to FFFF mid-sequence → no second sequence. Pushed bytes remain C0, DE.
6. Assert reset asynchronously (mid-cycle) during PUSH_L of a 3-byte push → immediate we=0, busy=0, sp_out=FF. No PUSH_P write. A subsequent start operates normally.

Source files
------------

// File: rtl/stack_push_seq.sv
// Serialises a 16-bit word (and optionally a status byte) onto the 8-bit bus as
// descending stack writes: high byte, low byte, then status.
module stack_push_seq #(
   parameter logic [7:0] STACK_PAGE = 8'h01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] word_in,
   input  logic [7:0]  status_in,
   input  logic        push_status,
   input  logic [7:0]  sp_in,
   input  logic        bus_rdy,
   output logic [15:0] addr_out,
   output logic [7:0]  data_out,
   output logic        we,
   output logic        busy,
   output logic        done,
   output logic [7:0]  sp_out
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PUSH_H = 3'd1,
      PUSH_L = 3'd2,
      PUSH_P = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  sp_q, sp_d;
   logic [15:0] word_q, word_d;
   logic [7:0]  status_q, status_d;
   logic        pstat_q, pstat_d;

   // State and capture registers; reset abandons any sequence in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sp_q     <= 8'hFF;
         word_q   <= 16'h0000;
         status_q <= 8'h00;
         pstat_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sp_q     <= sp_d;
         word_q   <= word_d;
         status_q <= status_d;
         pstat_q  <= pstat_d;
      end
   end

   // Next-state logic; a stalled bus holds the current PUSH state unchanged.
   always_comb begin
      state_d  = state_q;
      sp_d     = sp_q;
      word_d   = word_q;
      status_d = status_q;
      pstat_d  = pstat_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               word_d   = word_in;
               status_d = status_in;
               pstat_d  = push_status;
               sp_d     = sp_in;
               state_d  = PUSH_H;
            end else begin
               state_d = IDLE;
            end
         end
         PUSH_H: begin
            if (bus_rdy) begin
               sp_d    = sp_q - 8'd1;
               state_d = PUSH_L;
            end else begin
               state_d = PUSH_H;
            end
         end
         PUSH_L: begin
            if (bus_rdy) begin
               sp_d    = sp_q - 8'd1;
               state_d = pstat_q ? PUSH_P : DONE;
            end else begin
               state_d = PUSH_L;
            end
         end
         PUSH_P: begin
            if (bus_rdy) begin
               sp_d    = sp_q - 8'd1;
               state_d = DONE;
            end else begin
               state_d = PUSH_P;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode from the state and captured registers.
   always_comb begin
      addr_out = 16'h0000;
      data_out = 8'h00;
      we       = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      sp_out   = sp_q;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
         end
         PUSH_H: begin
            we       = 1'b1;
            busy     = 1'b1;
            addr_out = {STACK_PAGE, sp_q};
            data_out = word_q[15:8];
         end
         PUSH_L: begin
            we       = 1'b1;
            busy     = 1'b1;
            addr_out = {STACK_PAGE, sp_q};
            data_out = word_q[7:0];
         end
         PUSH_P: begin
            we       = 1'b1;
            busy     = 1'b1;
            addr_out = {STACK_PAGE, sp_q};
            data_out = status_q;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
